// File: rtl/rtc_pkg.sv
// Shared definitions for the V3023 RTC read/write sequencers:
// register map, sweep length, FSM state codes and BCD helpers.
package rtc_pkg;

  localparam int NUM_REG = 9;
  localparam int IDX_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_NEXT,
    S_COMMIT
  } state_e;

  // Index 0 is segundos, index 8 is thor.
  typedef logic [NUM_REG-1:0][7:0] bank_t;

  function automatic logic [7:0] addr_of(input logic [IDX_W-1:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h41;
      4'd7:    a = 8'h42;
      4'd8:    a = 8'h43;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic is_bcd(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/contador_refresco.sv
// Free-running modulo-MAX counter with synchronous clear-to-zero and a
// terminal-count flag; used for both the refresh period and the fin timeout.
module contador_refresco #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int           W    = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lectura_rtc.sv
// RTC read sequencer: sweeps the nine time/timer registers through the bus
// engine into a shadow bank and commits it atomically only after a clean sweep.
module lectura_rtc
  import rtc_pkg::*;
#(
  parameter int REFRESH = 10_000_000,
  parameter int TIMEOUT = 4096
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       habilitar,
  input  logic       fin,
  input  logic [7:0] Dato_in,
  output logic [7:0] ADD2,
  output logic       leer,
  output logic       ocupado,
  output logic       listo,
  output logic       error_bcd,
  output logic       error_bus,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic [7:0] tseg,
  output logic [7:0] tmin,
  output logic [7:0] thor
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REG - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       add2_q, add2_d;
  bank_t            shadow_q, shadow_d;
  bank_t            bank_q, bank_d;
  logic             bad_q, bad_d;
  logic             abort_q, abort_d;
  logic             hab_q, hab_d;
  logic             listo_q, listo_d;
  logic             ebcd_q, ebcd_d;
  logic             ebus_q, ebus_d;

  logic ref_tc, tmo_tc, trigger, start, hab_fall;

  assign trigger  = iniciar | (ref_tc & habilitar);
  assign start    = (state_q == S_IDLE) & trigger;
  assign hab_fall = hab_q & ~habilitar;

  contador_refresco #(.MAX(REFRESH)) u_refresco (
    .clk  (CLK),
    .rst  (reset),
    .load (start),
    .en   (habilitar),
    .tc   (ref_tc)
  );

  contador_refresco #(.MAX(TIMEOUT)) u_timeout (
    .clk  (CLK),
    .rst  (reset),
    .load (state_q == S_REQ),
    .en   (state_q == S_WAIT),
    .tc   (tmo_tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    add2_d   = add2_q;
    shadow_d = shadow_q;
    bank_d   = bank_q;
    bad_d    = bad_q;
    abort_d  = abort_q;
    hab_d    = habilitar;
    listo_d  = 1'b0;
    ebcd_d   = ebcd_q;
    ebus_d   = ebus_q;

    // A falling habilitar is remembered and acted on once the current
    // transaction has finished, so the bus engine is never left mid-cycle.
    if (state_q != S_IDLE && hab_fall) abort_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          idx_d   = '0;
          add2_d  = addr_of('0);
          bad_d   = 1'b0;
          abort_d = 1'b0;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (fin) begin
          shadow_d[idx_q] = Dato_in;
          if (!is_bcd(Dato_in)) bad_d = 1'b1;
          state_d = S_NEXT;
        end else if (tmo_tc) begin
          ebus_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_NEXT: begin
        if (abort_q || hab_fall) begin
          state_d = S_IDLE;
        end else if (idx_q == LAST_IDX) begin
          // Commit is registered on entry to COMMIT so listo and the new
          // bank appear in the same cycle.
          state_d = S_COMMIT;
          idx_d   = idx_q + IDX_W'(1);
          if (!bad_q) begin
            bank_d  = shadow_q;
            listo_d = 1'b1;
            ebcd_d  = 1'b0;
            ebus_d  = 1'b0;
          end else begin
            ebcd_d  = 1'b1;
          end
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          add2_d  = addr_of(idx_q + IDX_W'(1));
          state_d = S_REQ;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      add2_q   <= 8'h00;
      shadow_q <= '0;
      bank_q   <= '0;
      bad_q    <= 1'b0;
      abort_q  <= 1'b0;
      hab_q    <= 1'b0;
      listo_q  <= 1'b0;
      ebcd_q   <= 1'b0;
      ebus_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      add2_q   <= add2_d;
      shadow_q <= shadow_d;
      bank_q   <= bank_d;
      bad_q    <= bad_d;
      abort_q  <= abort_d;
      hab_q    <= hab_d;
      listo_q  <= listo_d;
      ebcd_q   <= ebcd_d;
      ebus_q   <= ebus_d;
    end
  end

  assign ADD2      = add2_q;
  assign leer      = (state_q == S_REQ);
  assign ocupado   = (state_q != S_IDLE);
  assign listo     = listo_q;
  assign error_bcd = ebcd_q;
  assign error_bus = ebus_q;

  assign segundos = bank_q[0];
  assign minutos  = bank_q[1];
  assign horas    = bank_q[2];
  assign dia      = bank_q[3];
  assign mes      = bank_q[4];
  assign anio     = bank_q[5];
  assign tseg     = bank_q[6];
  assign tmin     = bank_q[7];
  assign thor     = bank_q[8];

endmodule

// File: tb/tb_lectura_rtc.sv
// Scoreboard bench for lectura_rtc: a bus model answers leer requests, a
// monitor checks every leer address and every committed bank against queues.
module tb_lectura_rtc;
  import rtc_pkg::*;

  localparam int REFRESH = 100;
  localparam int TIMEOUT = 64;

  logic       CLK = 1'b0;
  logic       reset, iniciar, habilitar, fin;
  logic [7:0] Dato_in, ADD2;
  logic       leer, ocupado, listo, error_bcd, error_bus;
  logic [7:0] segundos, minutos, horas, dia, mes, anio, tseg, tmin, thor;

  logic       fin_bus, fin_stray;
  logic [7:0] dat_bus, dat_stray;
  assign fin     = fin_bus | fin_stray;
  assign Dato_in = fin_stray ? dat_stray : dat_bus;

  bank_t out_bank;
  assign out_bank = {thor, tmin, tseg, anio, mes, dia, horas, minutos, segundos};

  always #5 CLK = ~CLK;

  lectura_rtc #(.REFRESH(REFRESH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .reset(reset), .iniciar(iniciar), .habilitar(habilitar),
    .fin(fin), .Dato_in(Dato_in), .ADD2(ADD2), .leer(leer), .ocupado(ocupado),
    .listo(listo), .error_bcd(error_bcd), .error_bus(error_bus),
    .segundos(segundos), .minutos(minutos), .horas(horas), .dia(dia),
    .mes(mes), .anio(anio), .tseg(tseg), .tmin(tmin), .thor(thor)
  );

  int         n_chk = 0, n_fail = 0, n_leer = 0, n_listo = 0;
  int         cyc = 0, listo_cyc = 0, last_fin_cyc = 0;
  bank_t      rsp;
  logic       withhold = 1'b0;
  logic [7:0] withhold_addr = 8'h00;
  logic [7:0] exp_addr[$];
  bank_t      exp_bank[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [7:0] a);
    for (int i = 0; i < NUM_REG; i++)
      if (addr_of(IDX_W'(i)) == a) return i;
    return 0;
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Bus engine model: fin with data three cycles after each leer.
  initial begin
    logic [7:0] a;
    logic       ok;
    fin_bus = 1'b0;
    dat_bus = 8'h00;
    forever begin
      @(negedge CLK);
      if (leer && !reset) begin
        a  = ADD2;
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          if (reset) ok = 1'b0;
        end
        if (ok && !(withhold && a == withhold_addr)) begin
          fin_bus      = 1'b1;
          dat_bus      = rsp[idx_of(a)];
          last_fin_cyc = cyc;
          @(negedge CLK);
          fin_bus = 1'b0;
        end
      end
    end
  end

  // Monitor: pops and compares on every leer and listo.
  initial begin
    logic [7:0] ea;
    bank_t      eb;
    forever begin
      @(negedge CLK);
      if (!reset) begin
        if (leer) begin
          n_leer++;
          if (exp_addr.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL leer_unexpected: got ADD2=%0h expected no request", ADD2);
          end else begin
            ea = exp_addr.pop_front();
            chk("leer_addr", 72'(ADD2), 72'(ea));
          end
        end
        if (listo) begin
          n_listo++;
          listo_cyc = cyc;
          chk("fin_to_listo", 72'(cyc - last_fin_cyc), 72'(2));
          if (exp_bank.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL listo_unexpected: got bank %0h expected no commit", out_bank);
          end else begin
            eb = exp_bank.pop_front();
            chk("listo_bank", out_bank, eb);
          end
        end
      end
    end
  end

  task automatic set_rsp(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8);
    rsp = {b8, b7, b6, b5, b4, b3, b2, b1, b0};
  endtask

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(addr_of(IDX_W'(i)));
  endtask

  task automatic pulse_ini();
    @(negedge CLK); iniciar = 1'b1;
    @(negedge CLK); iniciar = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (ocupado && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk(nm, 72'(ocupado), 72'(0));
  endtask

  task automatic clean_sweep(input string nm);
    push_addrs(NUM_REG);
    exp_bank.push_back(rsp);
    pulse_ini();
    wait_idle(nm, 200);
  endtask

  initial begin
    int    l0, s0, c1, c2, k;
    bank_t ba;
    reset = 1'b1; iniciar = 1'b0; habilitar = 1'b0;
    fin_stray = 1'b0; dat_stray = 8'h00;
    set_rsp(8'h59, 8'h45, 8'h23, 8'h31, 8'h12, 8'h16, 8'h10, 8'h20, 8'h05);
    ba = rsp;
    repeat (2) @(negedge CLK);
    chk("reset_bank", out_bank, 72'(0));
    chk("reset_ctrl", 72'({ADD2, leer, ocupado, listo, error_bcd, error_bus}), 72'(0));
    reset = 1'b0;

    // 1: clean sweep
    push_addrs(NUM_REG);
    exp_bank.push_back(rsp);
    l0 = n_leer; s0 = n_listo;
    @(negedge CLK); iniciar = 1'b1;
    @(negedge CLK); iniciar = 1'b0;
    chk("first_leer_latency", 72'(leer), 72'(1));
    wait_idle("t1_idle", 200);
    chk("t1_leer_count", 72'(n_leer - l0), 72'(9));
    chk("t1_listo_count", 72'(n_listo - s0), 72'(1));
    chk("t1_bank", out_bank, ba);
    chk("t1_errors", 72'({error_bcd, error_bus}), 72'(0));

    // 2: non-BCD low nibble, then high nibble, then clean sweep
    set_rsp(8'h59, 8'h3A, 8'h23, 8'h31, 8'h12, 8'h16, 8'h10, 8'h20, 8'h05);
    push_addrs(NUM_REG);
    s0 = n_listo;
    pulse_ini();
    wait_idle("t2_idle", 200);
    chk("t2_no_listo", 72'(n_listo - s0), 72'(0));
    chk("t2_bank_kept", out_bank, ba);
    chk("t2_error_bcd", 72'({error_bcd, error_bus}), 72'(2));
    set_rsp(8'h59, 8'h45, 8'h23, 8'h31, 8'h12, 8'h16, 8'h10, 8'hA5, 8'h05);
    push_addrs(NUM_REG);
    pulse_ini();
    wait_idle("t2c_idle", 200);
    chk("t2c_no_listo", 72'(n_listo - s0), 72'(0));
    chk("t2c_bank_kept", out_bank, ba);
    chk("t2c_error_bcd", 72'(error_bcd), 72'(1));
    set_rsp(8'h58, 8'h44, 8'h22, 8'h30, 8'h11, 8'h15, 8'h09, 8'h19, 8'h04);
    ba = rsp;
    clean_sweep("t2b_idle");
    chk("t2b_bank", out_bank, ba);
    chk("t2b_error_cleared", 72'(error_bcd), 72'(0));

    // 3: fin withheld at horas -> timeout
    set_rsp(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
    withhold = 1'b1; withhold_addr = 8'h23;
    push_addrs(3);
    s0 = n_listo;
    pulse_ini();
    wait_idle("t3_idle", TIMEOUT + 60);
    chk("t3_error_bus", 72'({error_bcd, error_bus}), 72'(1));
    chk("t3_bank_kept", out_bank, ba);
    chk("t3_no_listo", 72'(n_listo - s0), 72'(0));
    withhold = 1'b0;
    ba = rsp;
    clean_sweep("t3b_idle");
    chk("t3b_bank", out_bank, ba);
    chk("t3b_error_cleared", 72'(error_bus), 72'(0));

    // 4: automatic refresh, then habilitar drops during register 4
    set_rsp(8'h12, 8'h34, 8'h56, 8'h28, 8'h02, 8'h99, 8'h59, 8'h59, 8'h23);
    ba = rsp;
    push_addrs(NUM_REG); push_addrs(NUM_REG); push_addrs(4);
    exp_bank.push_back(rsp); exp_bank.push_back(rsp);
    s0 = n_listo;
    @(negedge CLK); habilitar = 1'b1;
    k = 0;
    while (n_listo < s0 + 1 && k < 400) begin @(negedge CLK); k++; end
    chk("t4_first_sweep", 72'(n_listo - s0), 72'(1));
    c1 = listo_cyc;
    k = 0;
    while (n_listo < s0 + 2 && k < 400) begin @(negedge CLK); k++; end
    chk("t4_second_sweep", 72'(n_listo - s0), 72'(2));
    c2 = listo_cyc;
    chk("t4_refresh_period", 72'(c2 - c1), 72'(100));
    k = 0;
    while (!(leer && ADD2 == 8'h24) && k < 300) begin @(negedge CLK); k++; end
    chk("t4_reg4_reached", 72'(leer && ADD2 == 8'h24), 72'(1));
    habilitar = 1'b0;
    repeat (300) @(negedge CLK);
    chk("t4_abort_no_listo", 72'(n_listo - s0), 72'(2));
    chk("t4_abort_bank", out_bank, ba);
    chk("t4_abort_reqs_done", 72'(exp_addr.size()), 72'(0));
    chk("t4_abort_idle", 72'(ocupado), 72'(0));

    // 5: repeated iniciar during a sweep, stray fin in IDLE
    set_rsp(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
    ba = rsp;
    push_addrs(NUM_REG);
    exp_bank.push_back(rsp);
    l0 = n_leer;
    pulse_ini();
    for (int p = 0; p < 5; p++) begin
      repeat (5) @(negedge CLK);
      iniciar = 1'b1;
      @(negedge CLK);
      iniciar = 1'b0;
    end
    wait_idle("t5_idle", 200);
    chk("t5_leer_count", 72'(n_leer - l0), 72'(9));
    chk("t5_bank", out_bank, ba);
    @(negedge CLK); dat_stray = 8'h77; fin_stray = 1'b1;
    @(negedge CLK); fin_stray = 1'b0;
    repeat (5) @(negedge CLK);
    chk("t5_stray_bank", out_bank, ba);
    chk("t5_stray_idle", 72'({ocupado, listo}), 72'(0));
    chk("t5_stray_no_leer", 72'(n_leer - l0), 72'(9));

    // 6: async reset in WAIT, then clean restart
    set_rsp(8'h30, 8'h30, 8'h11, 8'h15, 8'h06, 8'h24, 8'h00, 8'h00, 8'h01);
    push_addrs(2);
    pulse_ini();
    k = 0;
    while (!(leer && ADD2 == 8'h22) && k < 40) begin @(negedge CLK); k++; end
    chk("t6_reg2_reached", 72'(leer && ADD2 == 8'h22), 72'(1));
    @(negedge CLK);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_bank", out_bank, 72'(0));
    chk("t6_async_ctrl", 72'({ADD2, leer, ocupado, listo, error_bcd, error_bus}), 72'(0));
    repeat (3) @(negedge CLK);
    chk("t6_leer_low", 72'(leer), 72'(0));
    reset = 1'b0;
    ba = rsp;
    clean_sweep("t6_idle");
    chk("t6_bank", out_bank, ba);

    chk("exp_addr_drained", 72'(exp_addr.size()), 72'(0));
    chk("exp_bank_drained", 72'(exp_bank.size()), 72'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
